// File: rtl/lp_ctrl_pkg.sv
// Shared types and constants for the LP receive controller: FSM states, LP line codes
// and default parameter values.
package lp_ctrl_pkg;

   localparam int SYNC_STAGES_DFLT = 2;
   localparam int FILT_CYCLES_DFLT = 3;
   localparam int TIMEOUT_DFLT     = 4096;
   localparam int CNT_W_DFLT       = 13;

   // {A,B,C} line codes
   localparam logic [2:0] LP_STOP    = 3'b111;
   localparam logic [2:0] LP_ESC_RQ  = 3'b100;
   localparam logic [2:0] LP_BRIDGE  = 3'b000;
   localparam logic [2:0] LP_ESC_ACK = 3'b010;
   localparam logic [2:0] LP_HS_RQ   = 3'b001;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_STOP,
      ST_ESC_RQST,
      ST_ESC_BRIDGE,
      ST_ESC_ACK,
      ST_ESC_ACTIVE,
      ST_HS_RQST,
      ST_HS_ACTIVE,
      ST_ERR_WAIT
   } lp_state_e;

   // States in which a stalled line sequence is aborted by the timeout counter.
   function automatic logic is_timed(input lp_state_e s);
      return s inside {ST_ESC_RQST, ST_ESC_BRIDGE, ST_ESC_ACK, ST_ESC_ACTIVE, ST_HS_RQST};
   endfunction

endpackage

// File: rtl/lp_line_filter.sv
// Synchronizes the raw {A,B,C} levels and accepts a new line state only after it has been
// seen on FILT_CYCLES consecutive synced samples; line_chg strobes with each accepted update.
module lp_line_filter
   import lp_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DFLT,
   parameter int FILT_CYCLES = FILT_CYCLES_DFLT
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       A,
   input  logic       B,
   input  logic       C,
   output logic [2:0] LineState,
   output logic       line_chg
);

   localparam int FW = $clog2(FILT_CYCLES + 1);

   logic [SYNC_STAGES-1:0][2:0] sync_q, sync_d;
   logic [2:0]                  cand_q, cand_d;
   logic [FW-1:0]               cnt_q, cnt_d;
   logic [2:0]                  line_q, line_d;
   logic                        chg_q, chg_d;
   logic [2:0]                  synced;

   assign synced = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], A, B, C};
      cand_d = synced;
      cnt_d  = cnt_q;
      line_d = line_q;
      chg_d  = 1'b0;
      // cnt_d is the length of the current run of identical synced samples
      if (synced != cand_q) begin
         cnt_d = FW'(1);
      end else if (cnt_q < FW'(FILT_CYCLES)) begin
         cnt_d = cnt_q + FW'(1);
      end
      if ((cnt_d >= FW'(FILT_CYCLES)) && (synced != line_q)) begin
         line_d = synced;
         chg_d  = 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync_q <= '0;
         cand_q <= '0;
         cnt_q  <= '0;
         line_q <= '0;
         chg_q  <= 1'b0;
      end else begin
         sync_q <= sync_d;
         cand_q <= cand_d;
         cnt_q  <= cnt_d;
         line_q <= line_d;
         chg_q  <= chg_d;
      end
   end

   assign LineState = line_q;
   assign line_chg  = chg_q;

endmodule

// File: rtl/lp_rx_ctrl.sv
// Slave-side LP receive controller: tracks the filtered LP line sequence and gates the
// escape decoder, with a stall timeout on the handshake and escape states.
//
// state         | meaning
// IDLE          | after reset, waiting for the first filtered Stop
// STOP          | lane in LP-11 Stop
// ESC_RQST      | LP-10 seen, escape requested
// ESC_BRIDGE    | LP-00 bridge after the request
// ESC_ACK       | LP-01 acknowledge
// ESC_ACTIVE    | decoder enabled, escape in progress
// HS_RQST       | LP-01 (001) HS request
// HS_ACTIVE     | HS entry accepted, held until Stop
// ERR_WAIT      | aborted, waiting for Stop
module lp_rx_ctrl
   import lp_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DFLT,
   parameter int FILT_CYCLES = FILT_CYCLES_DFLT,
   parameter int TIMEOUT     = TIMEOUT_DFLT,
   parameter int CNT_W       = CNT_W_DFLT
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       A,
   input  logic       B,
   input  logic       C,
   input  logic       LpFsmStop,
   input  logic       ErrEsc,
   input  logic       ErrControl,
   input  logic       ErrSyncEsc,
   output logic       EscDecoderEn,
   output logic       RequestDetection,
   output logic       Stopstate,
   output logic       HsEntry,
   output logic       EscDone,
   output logic       ErrLpSeq,
   output logic       ErrTimeout,
   output logic       ErrDecoder,
   output logic [2:0] LineState
);

   lp_state_e        state_q, state_d;
   logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             line_chg, dec_err, tmo_hit, seq_err, tmo_err;
   logic             en_q, en_d, req_q, req_d, stop_q, stop_d, hs_q, hs_d;
   logic             done_q, done_d, eseq_q, eseq_d, etmo_q, etmo_d, edec_q, edec_d;

   lp_line_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_CYCLES (FILT_CYCLES)
   ) u_line_filter (
      .CLK       (CLK),
      .RST       (RST),
      .A         (A),
      .B         (B),
      .C         (C),
      .LineState (LineState),
      .line_chg  (line_chg)
   );

   assign dec_err = ErrEsc | ErrControl | ErrSyncEsc;
   // a line change in this cycle means the sequence is moving, never a stall
   assign tmo_hit = !line_chg && (tmo_cnt_q >= CNT_W'(TIMEOUT - 1));

   always_comb begin
      tmo_cnt_d = tmo_cnt_q;
      if (line_chg || !is_timed(state_q)) begin
         tmo_cnt_d = '0;
      end else if (tmo_cnt_q != {CNT_W{1'b1}}) begin
         tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      req_d   = 1'b0;
      done_d  = 1'b0;
      edec_d  = 1'b0;
      seq_err = 1'b0;
      tmo_err = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_ERR_WAIT: begin
            if (LineState == LP_STOP) state_d = ST_STOP;
         end
         ST_STOP: begin
            if (LineState == LP_ESC_RQ)     state_d = ST_ESC_RQST;
            else if (LineState == LP_HS_RQ) state_d = ST_HS_RQST;
            else if (LineState != LP_STOP)  seq_err = 1'b1;
         end
         ST_ESC_RQST: begin
            if (LineState == LP_BRIDGE)       state_d = ST_ESC_BRIDGE;
            else if (LineState == LP_STOP)    state_d = ST_STOP;
            else if (LineState != LP_ESC_RQ)  seq_err = 1'b1;
            else if (tmo_hit)                 tmo_err = 1'b1;
         end
         ST_ESC_BRIDGE: begin
            if (LineState == LP_ESC_ACK)      state_d = ST_ESC_ACK;
            else if (LineState == LP_STOP)    state_d = ST_STOP;
            else if (LineState != LP_BRIDGE)  seq_err = 1'b1;
            else if (tmo_hit)                 tmo_err = 1'b1;
         end
         ST_ESC_ACK: begin
            if (LineState == LP_BRIDGE) begin
               state_d = ST_ESC_ACTIVE;
               req_d   = 1'b1;
            end
            else if (LineState == LP_STOP)    state_d = ST_STOP;
            else if (LineState != LP_ESC_ACK) seq_err = 1'b1;
            else if (tmo_hit)                 tmo_err = 1'b1;
         end
         ST_ESC_ACTIVE: begin
            if (dec_err) begin
               state_d = ST_ERR_WAIT;
               edec_d  = 1'b1;
            end else if (LpFsmStop || (LineState == LP_STOP)) begin
               state_d = ST_STOP;
               done_d  = 1'b1;
            end else if (tmo_hit) begin
               tmo_err = 1'b1;
            end
         end
         ST_HS_RQST: begin
            if (LineState == LP_BRIDGE)      state_d = ST_HS_ACTIVE;
            else if (LineState == LP_STOP)   state_d = ST_STOP;
            else if (LineState != LP_HS_RQ)  seq_err = 1'b1;
            else if (tmo_hit)                tmo_err = 1'b1;
         end
         ST_HS_ACTIVE: begin
            if (LineState == LP_STOP) state_d = ST_STOP;
         end
         default: state_d = ST_IDLE;
      endcase

      eseq_d = seq_err;
      etmo_d = tmo_err && !seq_err;
      if (seq_err || tmo_err) state_d = ST_ERR_WAIT;

      en_d   = (state_d == ST_ESC_ACTIVE);
      stop_d = (state_d == ST_STOP);
      hs_d   = (state_d == ST_HS_ACTIVE);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= ST_IDLE;
         tmo_cnt_q <= '0;
         en_q      <= 1'b0;
         req_q     <= 1'b0;
         stop_q    <= 1'b0;
         hs_q      <= 1'b0;
         done_q    <= 1'b0;
         eseq_q    <= 1'b0;
         etmo_q    <= 1'b0;
         edec_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         tmo_cnt_q <= tmo_cnt_d;
         en_q      <= en_d;
         req_q     <= req_d;
         stop_q    <= stop_d;
         hs_q      <= hs_d;
         done_q    <= done_d;
         eseq_q    <= eseq_d;
         etmo_q    <= etmo_d;
         edec_q    <= edec_d;
      end
   end

   assign EscDecoderEn     = en_q;
   assign RequestDetection = req_q;
   assign Stopstate        = stop_q;
   assign HsEntry          = hs_q;
   assign EscDone          = done_q;
   assign ErrLpSeq         = eseq_q;
   assign ErrTimeout       = etmo_q;
   assign ErrDecoder       = edec_q;

endmodule

// File: tb/tb_lp_rx_ctrl.sv
// Self-checking bench for lp_rx_ctrl: directed scenarios plus randomized line/decoder
// activity, compared every cycle against a behavioural model of the LP sequencing rules.
module tb_lp_rx_ctrl;

   localparam int S   = 2;
   localparam int F   = 3;
   localparam int TMO = 4096;
   localparam int W   = 13;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic A = 1'b1, B = 1'b1, C = 1'b1;
   logic LpFsmStop = 1'b0, ErrEsc = 1'b0, ErrControl = 1'b0, ErrSyncEsc = 1'b0;
   logic EscDecoderEn, RequestDetection, Stopstate, HsEntry, EscDone;
   logic ErrLpSeq, ErrTimeout, ErrDecoder;
   logic [2:0] LineState;
   logic [10:0] dut_outs;

   int total = 0;
   int bad   = 0;
   int n_req = 0, n_done = 0, n_eseq = 0, n_etmo = 0, n_edec = 0, n_not_stop = 0;

   always #5 CLK = ~CLK;

   lp_rx_ctrl #(
      .SYNC_STAGES (S),
      .FILT_CYCLES (F),
      .TIMEOUT     (TMO),
      .CNT_W       (W)
   ) dut (
      .CLK              (CLK),
      .RST              (RST),
      .A                (A),
      .B                (B),
      .C                (C),
      .LpFsmStop        (LpFsmStop),
      .ErrEsc           (ErrEsc),
      .ErrControl       (ErrControl),
      .ErrSyncEsc       (ErrSyncEsc),
      .EscDecoderEn     (EscDecoderEn),
      .RequestDetection (RequestDetection),
      .Stopstate        (Stopstate),
      .HsEntry          (HsEntry),
      .EscDone          (EscDone),
      .ErrLpSeq         (ErrLpSeq),
      .ErrTimeout       (ErrTimeout),
      .ErrDecoder       (ErrDecoder),
      .LineState        (LineState)
   );

   assign dut_outs = {EscDecoderEn, RequestDetection, Stopstate, HsEntry, EscDone,
                      ErrLpSeq, ErrTimeout, ErrDecoder, LineState};

   // ---------------- reference model ----------------
   localparam int M_IDLE = 0, M_STOP = 1, M_ERQ = 2, M_EBR = 3, M_EACK = 4;
   localparam int M_EACT = 5, M_HRQ = 6, M_HACT = 7, M_ERR = 8;

   int         m_state = M_IDLE;
   int         m_age   = 0;
   logic [2:0] m_line  = 3'b000;
   logic       m_chg   = 1'b0;
   logic [10:0] m_out  = '0;
   logic [2:0] hist [0:S+F-1];

   // handshake states: code that holds, code that advances, state it advances to
   task automatic seq_rule(input int st, output logic [2:0] hold_c, output logic [2:0] adv_c,
                           output int adv_to);
      case (st)
         M_ERQ:   begin hold_c = 3'b100; adv_c = 3'b000; adv_to = M_EBR;  end
         M_EBR:   begin hold_c = 3'b000; adv_c = 3'b010; adv_to = M_EACK; end
         M_EACK:  begin hold_c = 3'b010; adv_c = 3'b000; adv_to = M_EACT; end
         default: begin hold_c = 3'b001; adv_c = 3'b000; adv_to = M_HACT; end
      endcase
   endtask

   task automatic model_edge();
      logic req, done, e_seq, e_tmo, e_dec, timed, tmo, stable;
      logic [2:0] hold_c, adv_c, samp;
      int adv_to, nxt;
      if (RST) begin
         m_state = M_IDLE; m_age = 0; m_line = 3'b000; m_chg = 1'b0; m_out = '0;
         for (int k = 0; k < S + F; k++) hist[k] = 3'b000;
         return;
      end
      req = 0; done = 0; e_seq = 0; e_tmo = 0; e_dec = 0;
      nxt   = m_state;
      timed = (m_state == M_ERQ) || (m_state == M_EBR) || (m_state == M_EACK) ||
              (m_state == M_HRQ) || (m_state == M_EACT);
      tmo   = timed && !m_chg && (m_age >= TMO - 1);
      case (m_state)
         M_IDLE, M_ERR: if (m_line == 3'b111) nxt = M_STOP;
         M_STOP: begin
            if (m_line == 3'b100)      nxt = M_ERQ;
            else if (m_line == 3'b001) nxt = M_HRQ;
            else if (m_line != 3'b111) begin nxt = M_ERR; e_seq = 1; end
         end
         M_HACT: if (m_line == 3'b111) nxt = M_STOP;
         M_EACT: begin
            if (ErrEsc || ErrControl || ErrSyncEsc)      begin nxt = M_ERR;  e_dec = 1; end
            else if (LpFsmStop || m_line == 3'b111)      begin nxt = M_STOP; done = 1; end
            else if (tmo)                                begin nxt = M_ERR;  e_tmo = 1; end
         end
         default: begin
            seq_rule(m_state, hold_c, adv_c, adv_to);
            if (m_line == adv_c)       begin nxt = adv_to; req = (adv_to == M_EACT); end
            else if (m_line == 3'b111) nxt = M_STOP;
            else if (m_line == hold_c) begin if (tmo) begin nxt = M_ERR; e_tmo = 1; end end
            else                       begin nxt = M_ERR; e_seq = 1; end
         end
      endcase
      m_age = (timed && !m_chg) ? m_age + 1 : 0;

      // a line value is accepted once F consecutive synced samples agree
      samp   = hist[S-1];
      stable = 1'b1;
      for (int j = 0; j < F; j++) if (hist[S-1+j] != samp) stable = 1'b0;
      m_chg = stable && (samp != m_line);
      if (m_chg) m_line = samp;
      for (int k = S + F - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = {A, B, C};

      m_state = nxt;
      m_out = {nxt == M_EACT, req, nxt == M_STOP, nxt == M_HACT, done, e_seq, e_tmo, e_dec, m_line};
   endtask

   initial begin
      for (int k = 0; k < S + F; k++) hist[k] = 3'b000;
      forever begin
         @(posedge CLK or posedge RST);
         model_edge();
      end
   end

   // ---------------- checking / stimulus helpers ----------------
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         check_eq("outs", {21'd0, dut_outs}, {21'd0, m_out});
         if (RequestDetection)     n_req++;
         if (EscDone)              n_done++;
         if (ErrLpSeq)             n_eseq++;
         if (ErrTimeout)           n_etmo++;
         if (ErrDecoder)           n_edec++;
         if (LineState != 3'b111)  n_not_stop++;
      end
   endtask

   task automatic drive(input logic [2:0] v, input int n);
      {A, B, C} = v;
      step(n);
   endtask

   task automatic dec_pulse(input logic [3:0] v);
      {LpFsmStop, ErrEsc, ErrControl, ErrSyncEsc} = v;
      step(1);
      {LpFsmStop, ErrEsc, ErrControl, ErrSyncEsc} = 4'b0000;
   endtask

   task automatic esc_entry();
      drive(3'b100, 10);
      drive(3'b000, 10);
      drive(3'b010, 10);
      drive(3'b000, 10);
   endtask

   logic [2:0] esc_codes [0:3];
   int c0, c1;

   initial begin
      esc_codes[0] = 3'b100; esc_codes[1] = 3'b000; esc_codes[2] = 3'b010; esc_codes[3] = 3'b000;

      // 1: reset, then Stop after sync + filter + one FSM cycle
      step(3);
      check_eq("rst_outs", {21'd0, dut_outs}, 32'd0);
      RST = 1'b0;
      step(S + F);
      check_eq("stop_early", {31'd0, Stopstate}, 32'd0);
      step(1);
      check_eq("stop_at_6", {31'd0, Stopstate}, 32'd1);
      check_eq("line_111", {29'd0, LineState}, 32'd7);
      check_eq("no_en_in_stop", {31'd0, EscDecoderEn}, 32'd0);

      // 2: escape entry and normal exit
      c0 = n_req;
      esc_entry();
      check_eq("reqdet_once", n_req - c0, 1);
      check_eq("esc_en", {31'd0, EscDecoderEn}, 32'd1);
      dec_pulse(4'b1000);
      check_eq("esc_done", {31'd0, EscDone}, 32'd1);
      check_eq("stop_after_done", {31'd0, Stopstate}, 32'd1);
      check_eq("en_drop", {31'd0, EscDecoderEn}, 32'd0);
      drive(3'b111, 10);

      // 3: glitch rejection, then accepted short pulse
      c0 = n_not_stop;
      drive(3'b000, 2);
      drive(3'b111, 10);
      check_eq("glitch2_line", n_not_stop - c0, 0);
      check_eq("glitch2_stop", {31'd0, Stopstate}, 32'd1);
      c1 = n_eseq;
      drive(3'b000, 3);
      drive(3'b111, 3);
      check_eq("glitch3_err", {31'd0, ErrLpSeq}, 32'd1);
      check_eq("glitch3_left_stop", {31'd0, Stopstate}, 32'd0);
      step(10);
      check_eq("glitch3_err_once", n_eseq - c1, 1);
      check_eq("glitch3_back_stop", {31'd0, Stopstate}, 32'd1);

      // 4: HS entry, held through other codes until Stop
      drive(3'b001, 10);
      drive(3'b000, 10);
      check_eq("hs_entry", {31'd0, HsEntry}, 32'd1);
      c0 = n_eseq;
      drive(3'b100, 10);
      check_eq("hs_hold", {31'd0, HsEntry}, 32'd1);
      check_eq("hs_no_seq_err", n_eseq - c0, 0);
      drive(3'b111, 10);
      check_eq("hs_exit", {31'd0, HsEntry}, 32'd0);
      check_eq("hs_exit_stop", {31'd0, Stopstate}, 32'd1);

      // 5: decoder error beats LpFsmStop
      esc_entry();
      dec_pulse(4'b1010);
      check_eq("dec_err", {31'd0, ErrDecoder}, 32'd1);
      check_eq("dec_no_done", {31'd0, EscDone}, 32'd0);
      check_eq("dec_en_off", {31'd0, EscDecoderEn}, 32'd0);
      drive(3'b000, 10);
      check_eq("dec_wait", {31'd0, Stopstate}, 32'd0);
      drive(3'b111, 10);
      check_eq("dec_stop", {31'd0, Stopstate}, 32'd1);

      // 6: ESC_RQST entered on edge S+F+1, aborted TMO cycles later
      c0 = n_etmo;
      drive(3'b100, S + F + TMO);
      check_eq("tmo_not_yet", n_etmo - c0, 0);
      step(1);
      check_eq("tmo_pulse", {31'd0, ErrTimeout}, 32'd1);
      check_eq("tmo_not_stop", {31'd0, Stopstate}, 32'd0);
      step(5);
      check_eq("tmo_once", n_etmo - c0, 1);
      drive(3'b111, 10);

      // async reset in ESC_ACTIVE
      esc_entry();
      check_eq("pre_rst_en", {31'd0, EscDecoderEn}, 32'd1);
      RST = 1'b1;
      #1;
      check_eq("async_rst_en", {31'd0, EscDecoderEn}, 32'd0);
      check_eq("async_rst_line", {29'd0, LineState}, 32'd0);
      step(2);
      RST = 1'b0;
      drive(3'b000, 10);
      check_eq("rst_no_stop", {31'd0, Stopstate}, 32'd0);
      drive(3'b111, 10);
      check_eq("rst_fresh_stop", {31'd0, Stopstate}, 32'd1);

      // randomized episodes
      for (int e = 0; e < 250; e++) begin
         int kind;
         kind = int'($urandom_range(0, 4));
         if (kind <= 1) begin
            for (int i = 0; i < 4; i++) begin
               logic [2:0] code;
               code = esc_codes[i];
               if ($urandom_range(0, 9) == 0) code = 3'($urandom_range(0, 7));
               drive(code, int'($urandom_range(1, 9)));
            end
            for (int i = 0; i < 3; i++) begin
               step(int'($urandom_range(1, 10)));
               if ($urandom_range(0, 2) == 0) dec_pulse(4'($urandom_range(0, 15)));
            end
         end else if (kind == 2) begin
            drive(3'b001, int'($urandom_range(1, 9)));
            drive(3'b000, int'($urandom_range(1, 9)));
            drive(3'($urandom_range(0, 7)), int'($urandom_range(1, 9)));
         end else begin
            for (int i = 0; i < 3; i++) begin
               drive(3'($urandom_range(0, 7)), int'($urandom_range(1, 6)));
               if ($urandom_range(0, 3) == 0) dec_pulse(4'($urandom_range(0, 15)));
            end
         end
         drive(3'b111, int'($urandom_range(6, 12)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lp_rx_ctrl.md
Name: lp_rx_ctrl

Overview:
- Slave-side LP receive controller that sequences the escape-mode decoder.
- Samples the asynchronous LP line triplet {A,B,C}, synchronizes and deglitches it, and tracks the LP state sequence (Stop, Escape entry, HS request).
- Enables the decoder (EscDecoderEn/RequestDetection) only after a valid escape-entry handshake.
- Returns to Stop on decoder completion, line Stop, error or timeout; sits between the LP line receivers and the escape decoder / clock-recovery pair.

Parameters:
- SYNC_STAGES, 2, synchronizer flops per line (min 2).
- FILT_CYCLES, 3, consecutive identical synced samples required to accept a new line state (min 1).
- TIMEOUT, 4096, cycles without a filtered line-state change before aborting a non-Stop sequence.
- CNT_W, 13, width of the timeout counter (must hold TIMEOUT).

Ports:
- CLK  in  1  free-running controller clock.
- RST  in  1  asynchronous reset, active-high.
- A, B, C  in  1 each  raw LP line levels, asynchronous.
- LpFsmStop  in  1  decoder reports end of escape (pulse, CLK domain).
- ErrEsc, ErrControl, ErrSyncEsc  in  1 each  decoder error pulses, CLK domain.
- EscDecoderEn  out  1  decoder enable.
- RequestDetection  out  1  1-cycle pulse: decoder must capture entry command.
- Stopstate  out  1  lane in LP Stop.
- HsEntry  out  1  HS entry accepted; held until Stop.
- EscDone  out  1  1-cycle pulse on normal escape exit.
- ErrLpSeq  out  1  1-cycle pulse: illegal LP sequence.
- ErrTimeout  out  1  1-cycle pulse: timeout abort.
- ErrDecoder  out  1  1-cycle pulse: OR of decoder errors seen in ESC_ACTIVE.
- LineState  out  3  filtered {A,B,C}.

Behaviour:
- Reset: state IDLE. All outputs 0. LineState=3'b000. Synchronizers, filter and counter cleared.
- Filter: synced vector must be stable FILT_CYCLES cycles before LineState updates. Latency from raw edge to LineState = SYNC_STAGES+FILT_CYCLES cycles. Shorter glitches are ignored.
- LP codes: STOP=111, ESC_RQ=100, BRIDGE=000, ESC_ACK=010, HS_RQ=001.
- The FSM acts on LineState. All outputs are registered and change one cycle after the transition condition.
- IDLE: 111 -> STOP. Otherwise stay; no errors reported.
- STOP: Stopstate=1. 100 -> ESC_RQST. 001 -> HS_RQST. 111 stay. Any other code -> ERR_WAIT with ErrLpSeq.
- ESC_RQST: 000 -> ESC_BRIDGE. 111 -> STOP. 100 stay. Else ERR_WAIT with ErrLpSeq.
- ESC_BRIDGE: 010 -> ESC_ACK. 000 stay. 111 -> STOP. Else ERR_WAIT with ErrLpSeq.
- ESC_ACK: 000 -> ESC_ACTIVE, with RequestDetection pulsed on the entry cycle. 010 stay. 111 -> STOP. Else ERR_WAIT with ErrLpSeq.
- ESC_ACTIVE: EscDecoderEn=1. Exits, in priority order:
  - any decoder error -> ERR_WAIT with ErrDecoder;
  - else LpFsmStop or LineState==111 -> STOP with EscDone;
  - else timeout -> ERR_WAIT with ErrTimeout.
- HS_RQST: 000 -> HS_ACTIVE. 111 -> STOP. 001 stay. Else ERR_WAIT with ErrLpSeq.
- HS_ACTIVE: HsEntry=1. Only 111 -> STOP. Timeout and sequence checks are disabled.
- ERR_WAIT: all enables 0. Wait for 111 -> STOP.
- Timeout counter:
  - clears on any LineState change and in IDLE, STOP, HS_ACTIVE and ERR_WAIT;
  - otherwise increments, saturating;
  - reaching TIMEOUT in ESC_RQST/ESC_BRIDGE/ESC_ACK/HS_RQST/ESC_ACTIVE -> ERR_WAIT with ErrTimeout.
- Simultaneous events: decoder error beats LpFsmStop. Sequence error beats timeout in the same cycle. Only one error pulse fires per abort.
- EscDecoderEn drops the cycle the FSM leaves ESC_ACTIVE.
- Reset mid-sequence: all outputs go to 0 immediately (async). Sequencing restarts from IDLE, and re-entering STOP needs a fresh filtered 111.

Decomposition:
- Package lp_ctrl_pkg holds the FSM state enum, the five LP code constants and default parameter values.
- One sub-module, lp_line_filter, holds the synchronizer plus stability filter. Parameters SYNC_STAGES and FILT_CYCLES; inputs A/B/C; output LineState plus a 1-cycle change strobe.
- FSM and timeout counter live in lp_rx_ctrl.

Test Plan:
1. Reset, hold 111 -> Stopstate=1 exactly SYNC_STAGES+FILT_CYCLES+1 = 6 cycles after RST deasserts; all other outputs 0.
2. From Stop drive 100, 000, 010, 000 (each 10 cycles) -> RequestDetection one pulse on ESC_ACTIVE entry. EscDecoderEn=1 until an LpFsmStop pulse, then EscDone pulse, Stopstate=1.
3. In Stop inject a 2-cycle 000 glitch -> LineState stays 111, no state change; a 3-cycle pulse is accepted and gives ErrLpSeq, state ERR_WAIT.
4. Stop, 001, 000 -> HsEntry=1 and held. Line 111 -> HsEntry=0, Stopstate=1. Ignores 100 while in HS_ACTIVE.
5. In ESC_ACTIVE, assert ErrControl and LpFsmStop in the same cycle -> ErrDecoder=1, EscDone=0, EscDecoderEn=0 next cycle; Stop only after line returns to 111.
6. Hold 100 (ESC_RQST) for 4096 cycles -> ErrTimeout one pulse. Assert RST mid-ESC_ACTIVE -> EscDecoderEn=0 asynchronously, LineState=000.
